stream_pacer: RTL and testbench
===============================

# stream_pacer

Rate-paced byte-stream buffer that makes the `bhargava` input/output pacing synthesizable and parametrised. It accepts bytes from an upstream source into an internal FIFO and applies programmable-fullness backpressure. It releases bytes downstream in bursts of up to `burst_len`, one burst per programmable pulse period, and flags completion once the stream has ended and drained. It sits between a bursty producer (file loader, DMA) and a consumer that must be fed at a bounded rate.

## Interface

Parameters:
- `DATA_W`, 8, byte width of the stream.
- `DEPTH`, 16, FIFO entries; must be a power of two and at least 4.
- `PROG_MARGIN`, 2, `in_full` asserts when occupancy ≥ `DEPTH - PROG_MARGIN`.
- `PERIOD_W`, 7, width of the pulse period counter.
- `BL_W`, 4, width of `burst_len`.
- `CNT_W`, 32, width of the statistics counters.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `clk_en`, input, 1: global enable; when low, all state is frozen.
- `period`, input, `PERIOD_W`: a pulse fires every `period+1` cycles.
- `burst_len`, input, `BL_W`: maximum bytes per pulse; the value 0 is treated as 1.
- `in_data`, input, `DATA_W`: upstream byte.
- `in_en`, input, 1: write strobe for `in_data`.
- `in_full`, output, 1: programmable-full backpressure to upstream.
- `stream_end`, input, 1: end-of-stream indication; level or pulse, latched sticky.
- `out_data`, output, `DATA_W`: registered downstream byte.
- `out_en`, output, 1: one-cycle strobe; `out_data` is valid while it is high.
- `out_full`, input, 1: downstream cannot accept a byte this cycle.
- `done`, output, 1: sticky; the stream has ended and the FIFO is drained.
- `overflow`, output, 1: sticky; a write arrived while the FIFO was hard-full.
- `in_cnt`, `out_cnt`, `stall_cnt`, output, `CNT_W`: bytes accepted, bytes emitted, and cycles with `in_full` high.

## Operation

- **Clock enable.** Every register updates only when `clk_en` is high. While `clk_en` is low, `out_en` is forced to 0 and `in_en` is ignored.
- **FIFO push.** `in_en` pushes `in_data` when occupancy < `DEPTH`. A push into a hard-full FIFO is dropped: `overflow` sets to 1 and `in_cnt` does not increment.
- **FIFO pop.** A pop never uses the same-cycle write (no fall-through). Empty is decided from registered occupancy. A simultaneous push and pop leaves occupancy unchanged.
- **Backpressure.** `in_full` is derived combinationally from the registered occupancy only.
- **Pulse counter.** `pcnt` counts 0 up to `period_l`. The pulse is active in the cycle where `pcnt == period_l`, and `pcnt` then wraps to 0. `period_l` reloads from `period` at each wrap and at reset, so `period = 0` gives a pulse every cycle.
- **End of stream.** `end_seen` sets when `stream_end` is high and stays set until reset.
- **FSM, WAIT state.**
  - Pop condition: pulse && !empty && !out_full. The pop is issued and `rem` is set to `max(burst_len,1) - 1`.
  - If the pop condition holds and `rem` > 0, go to BURST.
  - Otherwise stay in WAIT. A pulse that cannot pop is lost.
  - If `end_seen` && empty with no pop this cycle, go to DONE.
- **FSM, BURST state.**
  - Each cycle with !empty && !out_full: pop and decrement `rem`; return to WAIT when `rem` reaches 0.
  - If `out_full` is high, hold without popping and keep `rem`.
  - If the FIFO is empty, truncate the burst and return to WAIT. Unused quota does not carry over.
  - Pulses arriving during BURST are ignored. The pulse counter keeps running.
- **FSM, DONE state.** Terminal until reset. `done` = 1 and no further pops occur. Pushes are still accepted and counted.
- **Counters.** `stall_cnt` increments on each enabled cycle with `in_full` high. All counters wrap modulo 2^`CNT_W`.

## Timing

- **Reset values** (reset is asynchronous, all outputs take these immediately):
  - `out_en`, `out_data`, `done`, `overflow`, all counters, `pcnt`: 0.
  - `in_full`: 0 (FIFO empty), state: WAIT, `end_seen`: 0, `period_l` = `period`.
- **Output latency.** A pop in cycle N produces `out_en` = 1 with that byte on `out_data` in cycle N+1. `out_data` holds its value while `out_en` is low.
- **Burst spacing.** A burst of k bytes with `out_full` low gives k consecutive `out_en` cycles. The first one follows the pulse cycle.
- **`in_full` timing.** It reflects a push in cycle N starting from cycle N+1.
- **`done` timing.** `done` asserts one cycle after the WAIT-state cycle in which `end_seen` && empty holds. When the FIFO empties by a pop, this is at the earliest two cycles after the last pop.
- **Reset during a burst.** The FIFO empties and the remaining bytes are discarded. The first pulse after release occurs at cycle `period` from release.

## Test plan

- **Single-byte pacing.** Set `period` = 3, `burst_len` = 1, and push 0x10..0x14 before the first pulse. Require `out_en` once every 4 cycles, bytes in order 0x10..0x14, and `out_cnt` = 5.
- **Burst and truncation.** Set `period` = 15, `burst_len` = 4, and preload 6 bytes. Require 4 consecutive `out_en` after pulse 1, then 2 after pulse 2 (truncated), and the FIFO empty.
- **Downstream stall.** Raise `out_full` for 3 cycles in the middle of a 4-byte burst. Require `out_en` low for exactly those cycles, the burst resuming afterwards, all 4 bytes delivered in order, and no pulse consumed.
- **Overflow.** With `DEPTH` = 16 and no pulses (`out_full` = 1), make 17 writes. Require `in_full` high from the cycle after the 14th write, `in_cnt` = 16, `overflow` = 1, and `stall_cnt` incrementing each cycle while `in_full` is high.
- **End of stream.** Push 3 bytes, pulse `stream_end`, then drain with `burst_len` = 1. Require `done` = 1 exactly 2 cycles after the last pop, `done` staying set, and no further `out_en`.
- **Reset mid-burst and clock enable.** Assert `rst_n` = 0 during a burst and require all outputs at 0 immediately and the FIFO empty after release. Separately, hold `clk_en` low for 5 cycles and require `pcnt`, the counters and the FSM to stay frozen and `out_en` to be 0.

Source files
------------

// File: rtl/stream_pacer.sv
// Rate-paced byte FIFO: accepts a bursty upstream stream with programmable-full
// backpressure and releases bursts of up to burst_len bytes once per pulse period.
module stream_pacer #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int PROG_MARGIN = 2,
    parameter int PERIOD_W    = 7,
    parameter int BL_W        = 4,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic [PERIOD_W-1:0] period,
    input  logic [BL_W-1:0]     burst_len,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_en,
    output logic                in_full,
    input  logic                stream_end,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_en,
    input  logic                out_full,
    output logic                done,
    output logic                overflow,
    output logic [CNT_W-1:0]    in_cnt,
    output logic [CNT_W-1:0]    out_cnt,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PROG_LVL = (AW+1)'(DEPTH - PROG_MARGIN);

    typedef enum logic [1:0] {S_WAIT, S_BURST, S_DONE} state_t;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         occ;
    logic [PERIOD_W-1:0] pcnt, period_l;
    logic [BL_W-1:0]     rem, bl_m1;
    state_t              state;
    logic                end_seen, out_en_q;
    logic                empty, hard_full, pulse, push, pop;

    assign empty     = (occ == '0);
    assign hard_full = (occ == FULL_LVL);
    assign in_full   = (occ >= PROG_LVL);
    assign pulse     = (pcnt == period_l);
    assign push      = clk_en && in_en && !hard_full;
    assign bl_m1     = (burst_len == '0) ? '0 : burst_len - BL_W'(1);
    assign out_en    = out_en_q && clk_en;

    // Pops are decided from registered occupancy only, so a same-cycle write never falls through.
    always_comb begin
        pop = 1'b0;
        if (clk_en && !empty && !out_full) begin
            case (state)
                S_WAIT:  pop = pulse;
                S_BURST: pop = 1'b1;
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            pcnt      <= '0;
            period_l  <= period;
            end_seen  <= 1'b0;
            overflow  <= 1'b0;
            out_en_q  <= 1'b0;
            out_data  <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            stall_cnt <= '0;
        end else if (clk_en) begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (pulse) begin
                pcnt     <= '0;
                period_l <= period;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (stream_end)          end_seen <= 1'b1;
            if (in_en && hard_full)  overflow <= 1'b1;
            out_en_q <= pop;
            if (pop) out_data <= mem[rd_ptr];
            in_cnt    <= in_cnt + CNT_W'(push);
            out_cnt   <= out_cnt + CNT_W'(pop);
            stall_cnt <= stall_cnt + CNT_W'(in_full);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
            rem   <= '0;
            done  <= 1'b0;
        end else if (clk_en) begin
            case (state)
                S_WAIT: begin
                    if (pop) begin
                        rem <= bl_m1;
                        if (bl_m1 != '0) state <= S_BURST;
                    end else if (end_seen && empty) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_BURST: begin
                    // An empty FIFO truncates the burst; leftover quota is dropped.
                    if (empty) begin
                        state <= S_WAIT;
                    end else if (!out_full) begin
                        rem <= rem - 1'b1;
                        if (rem == BL_W'(1)) state <= S_WAIT;
                    end
                end
                default: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_pacer.sv
// Directed bench for stream_pacer: scoreboard checks every emitted byte, main
// sequence checks cycle-exact strobes, flags and counters.
module tb_stream_pacer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clk_en = 1'b1;
    logic [6:0]  period = '0;
    logic [3:0]  burst_len = '0;
    logic [7:0]  in_data = '0;
    logic        in_en = 1'b0;
    logic        in_full;
    logic        stream_end = 1'b0;
    logic [7:0]  out_data;
    logic        out_en;
    logic        out_full = 1'b0;
    logic        done;
    logic        overflow;
    logic [31:0] in_cnt, out_cnt, stall_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb[$];
    logic [7:0]  sb_exp;

    stream_pacer dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .period(period),
        .burst_len(burst_len), .in_data(in_data), .in_en(in_en), .in_full(in_full),
        .stream_end(stream_end), .out_data(out_data), .out_en(out_en),
        .out_full(out_full), .done(done), .overflow(overflow), .in_cnt(in_cnt),
        .out_cnt(out_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_en"},    out_en,    0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_done"},      done,      0);
        check({tag, "_overflow"},  overflow,  0);
        check({tag, "_in_full"},   in_full,   0);
        check({tag, "_in_cnt"},    in_cnt,    0);
        check({tag, "_out_cnt"},   out_cnt,   0);
        check({tag, "_stall_cnt"}, stall_cnt, 0);
    endtask

    // Leaves the bench at cycle 0 just after reset release.
    task automatic do_reset(input logic [6:0] per, input logic [3:0] bl);
        in_en      = 1'b0;
        stream_end = 1'b0;
        out_full   = 1'b0;
        clk_en     = 1'b1;
        period     = per;
        burst_len  = bl;
        #1;
        rst_n = 1'b0;
        sb.delete();
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
    endtask

    // Scoreboard: every strobed byte must be the oldest one still expected.
    always @(negedge clk) begin
        if (rst_n && out_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL sb_extra observed=%0h expected=none", out_data);
            end else begin
                sb_exp = sb.pop_front();
                assert (out_data === sb_exp) else begin
                    errors++;
                    $error("FAIL sb_data observed=%0h expected=%0h", out_data, sb_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single-byte pacing: period 3, burst 1
        do_reset(7'd3, 4'd1);
        in_en = 1'b1; in_data = 8'h10; sb.push_back(in_data);
        for (int c = 1; c <= 24; c++) begin
            tick();
            check("t1_out_en", out_en, (c >= 4 && c <= 20 && c % 4 == 0));
            if (c < 5) begin
                in_data = 8'(8'h10 + c);
                sb.push_back(in_data);
            end else begin
                in_en = 1'b0;
            end
        end
        check("t1_out_cnt", out_cnt, 5);
        check("t1_in_cnt", in_cnt, 5);
        check("t1_sb_left", sb.size(), 0);

        // Burst of 4 then truncated burst of 2
        do_reset(7'd15, 4'd4);
        in_en = 1'b1; in_data = 8'h20; sb.push_back(in_data);
        for (int c = 1; c <= 40; c++) begin
            tick();
            check("t2_out_en", out_en, ((c >= 16 && c <= 19) || c == 32 || c == 33));
            if (c < 6) begin
                in_data = 8'(8'h20 + c);
                sb.push_back(in_data);
            end else begin
                in_en = 1'b0;
            end
        end
        check("t2_out_cnt", out_cnt, 6);
        check("t2_in_cnt", in_cnt, 6);
        check("t2_in_full", in_full, 0);
        check("t2_sb_left", sb.size(), 0);

        // Downstream stall in the middle of a 4-byte burst
        do_reset(7'd15, 4'd4);
        in_en = 1'b1; in_data = 8'h30; sb.push_back(in_data);
        for (int c = 1; c <= 40; c++) begin
            tick();
            check("t3_out_en", out_en, (c == 16 || c == 17 || c == 21 || c == 22));
            out_full = (c >= 17 && c <= 19);
            if (c < 4) begin
                in_data = 8'(8'h30 + c);
                sb.push_back(in_data);
            end else begin
                in_en = 1'b0;
            end
        end
        check("t3_out_cnt", out_cnt, 4);
        check("t3_sb_left", sb.size(), 0);

        // Overflow with downstream blocked
        do_reset(7'd3, 4'd1);
        out_full = 1'b1;
        in_en = 1'b1; in_data = 8'h40; sb.push_back(in_data);
        for (int c = 1; c <= 20; c++) begin
            tick();
            check("t4_in_full", in_full, (c >= 14));
            check("t4_in_cnt", in_cnt, (c < 16) ? c : 16);
            check("t4_overflow", overflow, (c >= 17));
            check("t4_stall_cnt", stall_cnt, (c > 14) ? c - 14 : 0);
            check("t4_out_en", out_en, 0);
            if (c < 17) begin
                in_data = 8'(8'h40 + c);
                if (c < 16) sb.push_back(in_data);
            end else begin
                in_en = 1'b0;
            end
        end

        // End of stream and drain to done
        do_reset(7'd3, 4'd1);
        in_en = 1'b1; in_data = 8'h50; sb.push_back(in_data);
        for (int c = 1; c <= 30; c++) begin
            tick();
            check("t5_out_en", out_en, (c == 4 || c == 8 || c == 12));
            check("t5_done", done, (c >= 13));
            stream_end = (c == 3);
            if (c < 3) begin
                in_data = 8'(8'h50 + c);
                sb.push_back(in_data);
            end else if (c == 20) begin
                in_en = 1'b1;
                in_data = 8'hEE;
            end else begin
                in_en = 1'b0;
            end
        end
        check("t5_in_cnt", in_cnt, 4);
        check("t5_out_cnt", out_cnt, 3);
        check("t5_sb_left", sb.size(), 0);

        // Reset asserted in the middle of a burst
        do_reset(7'd15, 4'd4);
        in_en = 1'b1; in_data = 8'h60; sb.push_back(in_data);
        for (int c = 1; c <= 17; c++) begin
            tick();
            check("t6_out_en", out_en, (c >= 16));
            if (c < 6) begin
                in_data = 8'(8'h60 + c);
                sb.push_back(in_data);
            end else begin
                in_en = 1'b0;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_mid");
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            check("t6_post_out_en", out_en, 0);
        end
        check("t6_post_out_cnt", out_cnt, 0);
        check("t6_post_in_full", in_full, 0);

        // Clock enable low for 5 cycles delays the pulse by 5
        do_reset(7'd7, 4'd1);
        in_en = 1'b1; in_data = 8'h70; sb.push_back(in_data);
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("t7_out_en", out_en, (c == 13));
            check("t7_in_cnt", in_cnt, 1);
            check("t7_out_cnt", out_cnt, (c >= 13));
            check("t7_stall_cnt", stall_cnt, 0);
            clk_en = !(c >= 2 && c <= 6);
            in_en = (c >= 2 && c <= 6);
            in_data = 8'h77;
        end
        check("t7_sb_left", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
